// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I/E integer core.
// Holds FSM state, ALU op enum, opcode/funct constants and the ALU function.
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_RSP = 3'd1,
        S_EXEC     = 3'd2,
        S_WB       = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic [31:0] alu(
        input alu_op_t     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  alu = a + b;
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << sh;
            ALU_SLT:  alu = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: alu = {31'd0, a < b};
            ALU_XOR:  alu = a ^ b;
            ALU_SRL:  alu = a >> sh;
            ALU_SRA:  alu = $unsigned($signed(a) >>> sh);
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            default:  alu = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: NUM_REGS x 32, two async reads, one sync write.
// Ports: clk, reset, raddr1/raddr2 -> rdata1/rdata2, we/waddr/wdata. x0 is zero.
module regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        rdata1 = 32'd0;
        rdata2 = 32'd0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == 5'(i)) rdata1 = regs_q[i];
            if (raddr2 == 5'(i)) rdata2 = regs_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (i != 0 && we && waddr == 5'(i)) regs_d[i] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) regs_q[i] <= 32'd0;
            else       regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I/E integer core: FETCH -> WAIT_RSP -> EXEC -> WB, HALT on illegal.
// Ports: clk, reset (sync, active-high), imem req/rsp handshake, pc_out,
// state_out, halted. Macro CPU_RETIRE_TRACE_EN adds retire_valid/pc/rd/data.
module multicycle_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [2:0]  state_out,
    output logic        halted
`ifdef CPU_RETIRE_TRACE_EN
    ,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_data
`endif
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] result_q, result_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] rs1_val, rs2_val;
    logic        legal;
    logic        uses_rs2;
    alu_op_t     op;
    logic        rf_we;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign imm    = {{20{ir_q[31]}}, ir_q[31:20]};

    regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (result_q)
    );

    // Decode. The funct7 ALT form selects SUB/SRA; it is legal only for those.
    always_comb begin
        legal    = 1'b0;
        uses_rs2 = 1'b0;
        op       = ALU_ADD;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        if (opcode == OPC_OP) begin
            uses_rs2 = 1'b1;
            if (f7 == F7_BASE) begin
                legal = 1'b1;
            end else if (f7 == F7_ALT) begin
                legal = (f3 == F3_ADD) || (f3 == F3_SR);
                if (f3 == F3_ADD) op = ALU_SUB;
            end
        end else if (opcode == OPC_OP_IMM) begin
            case (f3)
                F3_SLL:  legal = (f7 == F7_BASE);
                F3_SR:   legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end
        // RV32E: any referenced register above x15 makes the encoding illegal.
        if (NUM_REGS == 16) begin
            if (rs1[4] || rd[4] || (uses_rs2 && rs2[4])) legal = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        result_d       = result_q;
        rf_we          = 1'b0;
        imem_req_valid = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    ir_d    = imem_rsp_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (legal) begin
                    result_d = alu(op, rs1_val, uses_rs2 ? rs2_val : imm);
                    state_d  = S_WB;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_q + 32'd4;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign pc_out        = pc_q;
    assign state_out     = state_q;
    assign halted        = (state_q == S_HALT);

`ifdef CPU_RETIRE_TRACE_EN
    // Gated by reset so a core held in reset during WB never reports a retire.
    assign retire_valid = (state_q == S_WB) && !reset;
    assign retire_pc    = pc_q;
    assign retire_rd    = rd;
    assign retire_data  = result_q;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core (32- and 16-register builds).
// Scoreboard of expected rd/value/pc per instruction, checked at retirement.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    logic        a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_pc, b_pc;
    logic [2:0]  a_state, b_state;
    logic        a_halted, b_halted;
`ifdef CPU_RETIRE_TRACE_EN
    logic        a_rv, b_rv;
    logic [31:0] a_rpc, b_rpc, a_rdata, b_rdata;
    logic [4:0]  a_rrd, b_rrd;
`endif

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (a_valid),
        .imem_req_addr  (a_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .pc_out         (a_pc),
        .state_out      (a_state),
        .halted         (a_halted)
`ifdef CPU_RETIRE_TRACE_EN
        ,
        .retire_valid   (a_rv),
        .retire_pc      (a_rpc),
        .retire_rd      (a_rrd),
        .retire_data    (a_rdata)
`endif
    );

    multicycle_core #(.NUM_REGS(16)) dut16 (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (b_valid),
        .imem_req_addr  (b_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .pc_out         (b_pc),
        .state_out      (b_state),
        .halted         (b_halted)
`ifdef CPU_RETIRE_TRACE_EN
        ,
        .retire_valid   (b_rv),
        .retire_pc      (b_rpc),
        .retire_rd      (b_rrd),
        .retire_data    (b_rdata)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] reg_a(input int i);
        return dut.u_regfile.regs_q[i];
    endfunction

    task automatic run_instr(input logic [31:0] instr, input logic [4:0] rd,
                             input logic [31:0] val, input int stall);
        exp_t        e;
        int          cyc;
        logic [31:0] a0;
        e.rd = rd;
        e.data = val;
        e.pc = model_pc + 32'd4;
        sb.push_back(e);
        checks++;
        if (a_state !== 3'd0 || a_valid !== 1'b1 || a_addr !== model_pc) begin
            errors++;
            $display("FAIL fetch: state=%0d valid=%b addr=%h, want 0 1 %h",
                     a_state, a_valid, a_addr, model_pc);
        end
        a0 = a_addr;
        cyc = 0;
        for (int s = 0; s < stall; s++) begin
            req_ready = 1'b0;
            @(negedge clk);
            cyc++;
            checks++;
            if (a_state !== 3'd0 || a_valid !== 1'b1 || a_addr !== a0) begin
                errors++;
                $display("FAIL stall: state=%0d valid=%b addr=%h, want 0 1 %h",
                         a_state, a_valid, a_addr, a0);
            end
        end
        req_ready = 1'b1;
        @(negedge clk);
        cyc++;
        req_ready = 1'b0;
        checks++;
        if (a_state !== 3'd1) begin
            errors++;
            $display("FAIL wait_state: state=%0d, want 1", a_state);
        end
        rsp_valid = 1'b1;
        rsp_data = instr;
        @(negedge clk);
        cyc++;
        rsp_valid = 1'b0;
        rsp_data = 32'd0;
        while (a_state !== 3'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== 4 + stall) begin
            errors++;
            $display("FAIL cycles: got %0d, want %0d", cyc, 4 + stall);
        end
        checks++;
        if (reg_a(int'(e.rd)) !== e.data) begin
            errors++;
            $display("FAIL reg x%0d: got %h, want %h", e.rd, reg_a(int'(e.rd)), e.data);
        end
        checks++;
        if (a_pc !== e.pc) begin
            errors++;
            $display("FAIL pc: got %h, want %h", a_pc, e.pc);
        end
        model_pc = e.pc;
    endtask

    task automatic check_regs_zero(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (reg_a(i) !== 32'd0) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL %s regs: %0d nonzero, want 0", tag, nz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_pc = 32'd0;
        checks++;
        if (a_state !== 3'd0 || a_pc !== 32'd0 || a_halted !== 1'b0 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset: state=%0d pc=%h halted=%b valid=%b, want 0 0 0 1",
                     a_state, a_pc, a_halted, a_valid);
        end
        check_regs_zero("reset");
    endtask

    task automatic test_alu();
        run_instr(i_t(12'd5, 5'd0, 3'b000, 5'd1), 5'd1, 32'd5, 0);
        run_instr(i_t(12'hFFF, 5'd0, 3'b000, 5'd2), 5'd2, 32'hFFFF_FFFF, 0);
        run_instr(r_t(7'h00, 5'd2, 5'd0, 3'b011, 5'd3), 5'd3, 32'd1, 0);
        run_instr(r_t(7'h00, 5'd2, 5'd0, 3'b010, 5'd4), 5'd4, 32'd0, 0);
        run_instr(i_t(12'h404, 5'd2, 3'b101, 5'd5), 5'd5, 32'hFFFF_FFFF, 0);
        run_instr(i_t(12'h004, 5'd2, 3'b101, 5'd6), 5'd6, 32'h0FFF_FFFF, 0);
        run_instr(i_t(12'h123, 5'd0, 3'b000, 5'd7), 5'd7, 32'h123, 0);
        run_instr(r_t(7'h00, 5'd7, 5'd1, 3'b000, 5'd8), 5'd8, 32'h128, 0);
        run_instr(r_t(7'h20, 5'd7, 5'd1, 3'b000, 5'd9), 5'd9, 32'hFFFF_FEE2, 0);
        run_instr(r_t(7'h00, 5'd1, 5'd7, 3'b001, 5'd10), 5'd10, 32'h2460, 0);
        run_instr(r_t(7'h00, 5'd1, 5'd9, 3'b101, 5'd11), 5'd11, 32'h07FF_FFF7, 0);
        run_instr(r_t(7'h20, 5'd1, 5'd9, 3'b101, 5'd12), 5'd12, 32'hFFFF_FFF7, 0);
        run_instr(r_t(7'h00, 5'd2, 5'd7, 3'b100, 5'd13), 5'd13, 32'hFFFF_FEDC, 0);
        run_instr(r_t(7'h00, 5'd7, 5'd1, 3'b110, 5'd14), 5'd14, 32'h127, 0);
        run_instr(r_t(7'h00, 5'd7, 5'd1, 3'b111, 5'd15), 5'd15, 32'h1, 0);
        run_instr(r_t(7'h00, 5'd0, 5'd2, 3'b010, 5'd16), 5'd16, 32'd1, 0);
        run_instr(i_t(12'd0, 5'd2, 3'b010, 5'd17), 5'd17, 32'd1, 0);
        run_instr(i_t(12'd6, 5'd1, 3'b011, 5'd18), 5'd18, 32'd1, 0);
        run_instr(i_t(12'hFFF, 5'd1, 3'b100, 5'd19), 5'd19, 32'hFFFF_FFFA, 0);
        run_instr(i_t(12'h7F0, 5'd1, 3'b110, 5'd20), 5'd20, 32'h7F5, 0);
        run_instr(i_t(12'h0F0, 5'd7, 3'b111, 5'd21), 5'd21, 32'h20, 0);
        run_instr(i_t(12'd31, 5'd1, 3'b001, 5'd22), 5'd22, 32'h8000_0000, 0);
        run_instr(r_t(7'h00, 5'd8, 5'd1, 3'b001, 5'd23), 5'd23, 32'h500, 0);
    endtask

    task automatic test_stall();
        run_instr(i_t(12'd77, 5'd0, 3'b000, 5'd24), 5'd24, 32'd77, 3);
    endtask

    task automatic test_x0();
        run_instr(i_t(12'd7, 5'd0, 3'b000, 5'd1), 5'd1, 32'd7, 0);
        run_instr(r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd0), 5'd0, 32'd0, 0);
    endtask

    task automatic test_reset_mid();
        bit retired;
        retired = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        checks++;
        if (a_state !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset state: got %0d, want 1", a_state);
        end
        reset = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = i_t(12'd9, 5'd0, 3'b000, 5'd25);
        @(negedge clk);
        reset = 1'b0;
`ifdef CPU_RETIRE_TRACE_EN
        if (a_rv === 1'b1) retired = 1'b1;
`endif
        checks++;
        if (a_state !== 3'd0 || a_pc !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d pc=%h, want 0 0", a_state, a_pc);
        end
        check_regs_zero("mid_reset");
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data = 32'd0;
`ifdef CPU_RETIRE_TRACE_EN
        if (a_rv === 1'b1) retired = 1'b1;
`endif
        checks++;
        if (a_state !== 3'd0 || retired) begin
            errors++;
            $display("FAIL ignore_rsp: state=%0d retired=%b, want 0 0", a_state, retired);
        end
        check_regs_zero("ignore_rsp");
        model_pc = 32'd0;
    endtask

    task automatic test_rv32e();
        run_instr(i_t(12'd7, 5'd0, 3'b000, 5'd1), 5'd1, 32'd7, 0);
        run_instr(r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd17), 5'd17, 32'd14, 0);
        checks++;
        if (b_halted !== 1'b1 || b_valid !== 1'b0 || b_pc !== 32'd4) begin
            errors++;
            $display("FAIL rv32e: halted=%b valid=%b pc=%h, want 1 0 4",
                     b_halted, b_valid, b_pc);
        end
        checks++;
        if (dut16.u_regfile.regs_q[1] !== 32'd7) begin
            errors++;
            $display("FAIL rv32e x1: got %h, want 7", dut16.u_regfile.regs_q[1]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] r17;
        r17 = reg_a(17);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = 32'd0;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_halted !== 1'b1 || a_valid !== 1'b0 || a_pc !== model_pc || a_state !== 3'd4) begin
            errors++;
            $display("FAIL halt: halted=%b valid=%b pc=%h state=%0d, want 1 0 %h 4",
                     a_halted, a_valid, a_pc, a_state, model_pc);
        end
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = i_t(12'd1, 5'd0, 3'b000, 5'd17);
        repeat (4) @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        checks++;
        if (a_halted !== 1'b1 || a_valid !== 1'b0 || a_pc !== model_pc || reg_a(17) !== r17) begin
            errors++;
            $display("FAIL halt_hold: halted=%b valid=%b pc=%h x17=%h, want 1 0 %h %h",
                     a_halted, a_valid, a_pc, reg_a(17), model_pc, r17);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_stall();
        test_x0();
        test_reset_mid();
        test_rv32e();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
